uart_rx_deframer: RTL and testbench

//  Receiver for the rs232_rx line of soc_top: 8N1 asynchronous serial, LSB first, idle high.
//  It is the far end of the host-side byte sender used on the bench: 1 start bit, 8 data bits, 1 stop bit.
//  It recovers bytes and hands them to the command decoder (e.g. 0x41 = arm scope, 0x52 = set trigger).
//  The hand-off is a valid/ready holding register. Framing and overrun errors are reported as 1-cycle pulses.

---
 rtl/uart_rx_deframer_if.sv | 20 ++
 rtl/uart_rx_deframer.sv | 132 +++++++++++++
 tb/tb_uart_rx_deframer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// rtl/uart_rx_deframer_if.sv - received-byte holding register hand-off (valid/ready)
`timescale 1ns/1ps

interface uart_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 serial receiver with valid/ready byte hand-off
`timescale 1ns/1ps

module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 100,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    uart_rx_deframer_if.master     rx,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic             rxd_m;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rxd_m       <= 1'b1;
            rxd_s       <= 1'b1;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx.rx_data  <= 8'h00;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rxd_m     <= rxd;
            rxd_s     <= rxd_m;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (rx.rx_valid && rx.rx_ready)
                rx.rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                // Mid-start-bit check rejects short glitches on the idle line.
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt        <= '0;
                        shift[idx] <= rxd_s;
                        if (idx == 3'd7)
                            state <= STOP;
                        else
                            idx <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Leaving at mid-stop-bit gives half a bit of slack to re-arm.
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rxd_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx.rx_valid || rx.rx_ready) begin
                                rx.rx_data  <= shift;
                                rx.rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed scoreboard bench for uart_rx_deframer
`timescale 1ns/1ps

module tb_uart_rx_deframer;

    localparam int CPB    = 100;
    localparam int BIT_NS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_deframer_if rx_if ();

    uart_rx_deframer #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx        (rx_if.master),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    int         n_xfer, n_rise, n_ferr, n_ovr, n_valid_cyc, n_busy_cyc;
    longint     rise_t;
    longint     t0;
    logic       prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clear_counts();
        n_xfer      = 0;
        n_rise      = 0;
        n_ferr      = 0;
        n_ovr       = 0;
        n_valid_cyc = 0;
        n_busy_cyc  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_ns);
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(BIT_NS);
        end
        rxd = stop_bit;
        #(stop_ns);
        rxd = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.rx_valid && !prev_valid) begin
                n_rise++;
                rise_t = $time;
            end
            if (rx_if.rx_valid) n_valid_cyc++;
            if (busy)           n_busy_cyc++;
            if (frame_err)      n_ferr++;
            if (overrun)        n_ovr++;
            if (frame_err || overrun)
                check("err_pulse_clean",
                      {30'b0, frame_err & overrun, rx_if.rx_valid & ~prev_valid}, 32'h0);
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                n_xfer++;
                check("xfer_expected", {31'b0, exp_q.size() > 0}, 32'h1);
                if (exp_q.size() > 0)
                    check("xfer_data", {24'b0, rx_if.rx_data}, {24'b0, exp_q.pop_front()});
            end
        end
        prev_valid = rx_if.rx_valid;
    end

    initial begin
        logic [7:0] b;
        rx_if.rx_ready = 1'b1;
        clear_counts();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data",   {24'b0, rx_if.rx_data}, 32'h0);
        check("reset_rx_valid",  {31'b0, rx_if.rx_valid}, 32'h0);
        check("reset_frame_err", {31'b0, frame_err}, 32'h0);
        check("reset_overrun",   {31'b0, overrun}, 32'h0);
        check("reset_busy",      {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #(500);

        // 0x41 with the consumer always ready
        #3;
        clear_counts();
        exp_q.push_back(8'h41);
        t0 = $time;
        send_byte(8'h41, 1'b1, BIT_NS);
        #(2000);
        check_range("latency_cycles", int'((rise_t - t0) / 10), 951, 955);
        check("t41_rise",      n_rise, 1);
        check("t41_valid_cyc", n_valid_cyc, 1);
        check("t41_xfer",      n_xfer, 1);
        check("t41_ferr",      n_ferr, 0);

        // 300 ns glitch on the idle line
        clear_counts();
        rxd = 1'b0;
        #(300);
        rxd = 1'b1;
        #(2000);
        check_range("glitch_busy_cycles", n_busy_cyc, 1, 59);
        check("glitch_rise", n_rise, 0);
        check("glitch_ferr", n_ferr, 0);
        check("glitch_busy", {31'b0, busy}, 32'h0);

        // 0x55 with stop bit held low, then 0xA5
        clear_counts();
        send_byte(8'h55, 1'b0, 3000);
        #(2000);
        check("break_ferr", n_ferr, 1);
        check("break_rise", n_rise, 0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, BIT_NS);
        #(2000);
        check("a5_rise", n_rise, 1);
        check("a5_xfer", n_xfer, 1);
        check("a5_ferr", n_ferr, 1);

        // Overrun: two bytes while the consumer stalls
        clear_counts();
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(8'h52);
        send_byte(8'h52, 1'b1, BIT_NS);
        send_byte(8'h00, 1'b1, BIT_NS);
        #(2000);
        check("ovr_count",    n_ovr, 1);
        check("ovr_ferr",     n_ferr, 0);
        check("ovr_valid",    {31'b0, rx_if.rx_valid}, 32'h1);
        check("ovr_held",     {24'b0, rx_if.rx_data}, 32'h52);
        check("ovr_no_xfer",  n_xfer, 0);
        @(posedge clk);
        #1 rx_if.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("ovr_drained",  {31'b0, rx_if.rx_valid}, 32'h0);
        check("ovr_xfer",     n_xfer, 1);
        check("ovr_q_empty",  exp_q.size(), 0);

        // Reset during data bit 4 of 0xFF, then 0x3C
        clear_counts();
        fork
            send_byte(8'hFF, 1'b1, BIT_NS);
            begin
                #(5500);
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("mid_rst_rx_data",   {24'b0, rx_if.rx_data}, 32'h0);
                check("mid_rst_rx_valid",  {31'b0, rx_if.rx_valid}, 32'h0);
                check("mid_rst_busy",      {31'b0, busy}, 32'h0);
                check("mid_rst_frame_err", {31'b0, frame_err}, 32'h0);
                check("mid_rst_overrun",   {31'b0, overrun}, 32'h0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        #(2000);
        check("mid_rst_no_byte", n_rise, 0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1, BIT_NS);
        #(2000);
        check("t3c_xfer", n_xfer, 1);

        // Ten random bytes back-to-back
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, 1'b1, BIT_NS);
        end
        #(2000);
        check("burst_xfer",    n_xfer, 10);
        check("burst_ferr",    n_ferr, 0);
        check("burst_ovr",     n_ovr, 0);
        check("burst_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
